// File: rtl/timer_ctrl.sv
// timer_ctrl: counts simple_timer rollover ticks against a programmed period and raises a sticky irq
// Optional feature macro: TIMER_CTRL_OVERRUN_EN (adds overrun_o)
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   start_i, stop_i       1-cycle pulses: (re)load period/mode and run, or abort without irq
//   mode_i, period_i      0 = one-shot, 1 = periodic; ticks per period (0 is ignored)
//   irq_clr_i             clears irq_o (and overrun_o)
//   tick_i                rollover pulse from simple_timer
//   timer_en_o, busy_o    high while running
//   ticks_left_o          remaining ticks in the current period, 0 when idle
//   irq_o                 sticky expiry interrupt
//   overrun_o             expiry while irq_o still pending (macro only)
module timer_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] period_i,
  input  logic                 irq_clr_i,
  input  logic                 tick_i,
  output logic                 timer_en_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] ticks_left_o,
  output logic                 irq_o
`ifdef TIMER_CTRL_OVERRUN_EN
  ,
  output logic                 overrun_o
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, per_r, per_n;
  logic mode_r, mode_n, expire, irq_n, load;
  // stop_i outranks start_i, and a zero period never starts or restarts a run
  assign load = start_i && !stop_i && period_i != '0;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state  <= IDLE;
      cnt    <= '0;
      per_r  <= '0;
      mode_r <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      per_r  <= per_n;
      mode_r <= mode_n;
      irq_o  <= irq_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    per_n   = per_r;
    mode_n  = mode_r;
    expire  = 1'b0;
    if (state == IDLE) begin
      if (load) begin
        state_n = RUN;
        cnt_n   = period_i;
        per_n   = period_i;
        mode_n  = mode_i;
      end
    end else if (stop_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (load) begin
      cnt_n  = period_i;
      per_n  = period_i;
      mode_n = mode_i;
    end else if (tick_i) begin
      if (cnt > CNT_WIDTH'(1)) cnt_n = cnt - CNT_WIDTH'(1);
      else begin
        expire  = 1'b1;
        state_n = mode_r ? RUN : IDLE;
        cnt_n   = mode_r ? per_r : '0;
      end
    end
  end
  // set outranks a same-cycle clear
  assign irq_n        = expire | (irq_o & ~irq_clr_i);
  assign timer_en_o   = state == RUN;
  assign busy_o       = state == RUN;
  assign ticks_left_o = cnt;
`ifdef TIMER_CTRL_OVERRUN_EN
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) overrun_o <= 1'b0;
    else overrun_o <= (expire & irq_o) | (overrun_o & ~irq_clr_i);
`endif
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed stimulus with a cycle-tagged expectation queue checked by a separate monitor
module tb_timer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, mode = 1'b0, irq_clr = 1'b0, tick = 1'b0;
  logic [15:0] period = '0;
  logic timer_en, busy, irq, overrun;
  logic [15:0] ticks_left;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {
    int cyc;
    string name;
    logic busy, en;
    logic [15:0] ticks;
    logic irq, ovr;
  } exp_t;
  exp_t sb[$];
  timer_ctrl #(.CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .stop_i(stop), .mode_i(mode),
    .period_i(period), .irq_clr_i(irq_clr), .tick_i(tick), .timer_en_o(timer_en),
    .busy_o(busy), .ticks_left_o(ticks_left), .irq_o(irq)
`ifdef TIMER_CTRL_OVERRUN_EN
    , .overrun_o(overrun)
`endif
  );
`ifndef TIMER_CTRL_OVERRUN_EN
  assign overrun = 1'b0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic expect_at(input int c, input logic eb, ee, input logic [15:0] et,
                           input logic ei, eo, input string nm);
    exp_t e;
    e.cyc = c; e.name = nm; e.busy = eb; e.en = ee; e.ticks = et; e.irq = ei; e.ovr = eo;
    sb.push_back(e);
  endtask
  // drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input logic st, sp, md, input logic [15:0] p, input logic cl, tk,
                      input logic eb, ee, input logic [15:0] et, input logic ei, eo,
                      input string nm);
    start = st; stop = sp; mode = md; period = p; irq_clr = cl; tick = tk;
    expect_at(cyc + 1, eb, ee, et, ei, eo, nm);
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; irq_clr = 1'b0; tick = 1'b0;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc || busy !== e.busy || timer_en !== e.en || ticks_left !== e.ticks ||
            irq !== e.irq || overrun !== e.ovr) begin
          failures++;
          $display("FAIL %s cyc=%0d/%0d got busy=%b en=%b ticks=%h irq=%b ovr=%b want busy=%b en=%b ticks=%h irq=%b ovr=%b",
                   e.name, cyc, e.cyc, busy, timer_en, ticks_left, irq, overrun,
                   e.busy, e.en, e.ticks, e.irq, e.ovr);
        end
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_at(cyc, 0, 0, 16'd0, 0, 0, "reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // one-shot, period 3
    step(1, 0, 0, 16'd3, 0, 0, 1, 1, 16'd3, 0, 0, "os_start");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd2, 0, 0, "os_t1");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 0, 0, "os_t2");
    step(0, 0, 0, 16'd0, 0, 1, 0, 0, 16'd0, 1, 0, "os_expire");
    step(0, 0, 0, 16'd0, 0, 0, 0, 0, 16'd0, 1, 0, "os_irq_sticky");
    step(0, 0, 0, 16'd0, 1, 0, 0, 0, 16'd0, 0, 0, "os_clr");
    // periodic, period 2
    step(1, 0, 1, 16'd2, 0, 0, 1, 1, 16'd2, 0, 0, "per_start");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 0, 0, "per_t1");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd2, 1, 0, "per_t2");
    step(0, 0, 0, 16'd0, 1, 0, 1, 1, 16'd2, 0, 0, "per_clr");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 0, 0, "per_t3");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd2, 1, 0, "per_t4");
    step(0, 0, 0, 16'd0, 1, 0, 1, 1, 16'd2, 0, 0, "per_clr2");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 0, 0, "per_t5");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd2, 1, 0, "per_t6");
    step(0, 1, 0, 16'd0, 0, 0, 0, 0, 16'd0, 1, 0, "per_stop_keeps_irq");
    step(0, 0, 0, 16'd0, 1, 0, 0, 0, 16'd0, 0, 0, "per_clr3");
    // stop together with the expiring tick
    step(1, 0, 0, 16'd2, 0, 0, 1, 1, 16'd2, 0, 0, "stop_start");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 0, 0, "stop_t1");
    step(0, 1, 0, 16'd0, 0, 1, 0, 0, 16'd0, 0, 0, "stop_vs_tick");
    // illegal period, restart, priority
    step(1, 0, 0, 16'd0, 0, 0, 0, 0, 16'd0, 0, 0, "idle_p0_ignored");
    step(1, 1, 0, 16'd5, 0, 0, 0, 0, 16'd0, 0, 0, "idle_stop_beats_start");
    step(1, 0, 0, 16'd5, 0, 0, 1, 1, 16'd5, 0, 0, "rs_start5");
    step(1, 0, 0, 16'd9, 0, 0, 1, 1, 16'd9, 0, 0, "rs_restart9");
    step(1, 0, 0, 16'd1, 0, 0, 1, 1, 16'd1, 0, 0, "rs_restart1");
    step(1, 0, 0, 16'd4, 0, 1, 1, 1, 16'd4, 0, 0, "rs_start_vs_expire");
    step(1, 0, 1, 16'd0, 0, 0, 1, 1, 16'd4, 0, 0, "run_p0_ignored");
    step(1, 1, 0, 16'd7, 0, 0, 0, 0, 16'd0, 0, 0, "run_stop_beats_start");
    // irq set/clear race on a one-shot expiry
    step(1, 0, 0, 16'd2, 0, 0, 1, 1, 16'd2, 0, 0, "race_start");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 0, 0, "race_t1");
    step(0, 0, 0, 16'd0, 1, 1, 0, 0, 16'd0, 1, 0, "race_set_wins");
    step(0, 0, 0, 16'd0, 1, 0, 0, 0, 16'd0, 0, 0, "race_clr");
    // maximum period, no wrap
    step(1, 0, 0, 16'hFFFF, 0, 0, 1, 1, 16'hFFFF, 0, 0, "max_start");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'hFFFE, 0, 0, "max_t1");
    step(0, 1, 0, 16'd0, 0, 0, 0, 0, 16'd0, 0, 0, "max_stop");
`ifdef TIMER_CTRL_OVERRUN_EN
    step(1, 0, 1, 16'd1, 0, 0, 1, 1, 16'd1, 0, 0, "ovr_start");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 1, 0, "ovr_t1");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 1, 1, "ovr_t2");
    step(0, 0, 0, 16'd0, 1, 0, 1, 1, 16'd1, 0, 0, "ovr_clr");
    step(0, 1, 0, 16'd0, 0, 0, 0, 0, 16'd0, 0, 0, "ovr_stop");
`endif
    // async reset mid-run with irq pending and cnt=4
    step(1, 0, 1, 16'd1, 0, 0, 1, 1, 16'd1, 0, 0, "ar_start1");
    step(0, 0, 0, 16'd0, 0, 1, 1, 1, 16'd1, 1, 0, "ar_irq");
    step(1, 0, 1, 16'd4, 0, 0, 1, 1, 16'd4, 1, 0, "ar_start4");
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_at(cyc, 0, 0, 16'd0, 0, 0, "async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 16'd0, 0, 1, 0, 0, 16'd0, 0, 0, "post_reset_idle");
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
